// File: rtl/iob_native_mem_resp.sv
// ============================================================================
// Module  : iob_native_mem_resp
// Brief   : Native-interface word memory responder with programmable latency.
// Revision: 1.0
// ============================================================================
`default_nettype none

module iob_native_mem_resp #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int LATENCY    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                stall,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                busy
);

    localparam int         STRB_W   = DATA_W / 8;
    localparam int         OFFS_W   = $clog2(STRB_W);
    localparam int         DEPTH    = 1 << MEM_ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [MEM_ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  ready_q;
    logic                  busy_q;

    // Byte offset and address bits above the memory depth are dropped (aliasing).
    logic [MEM_ADDR_W-1:0] in_idx;
    assign in_idx = addr[OFFS_W +: MEM_ADDR_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid) begin
                        idx_q   <= in_idx;
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                        busy_q  <= 1'b1;
                        if (LATENCY <= 1) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            if (wstrb == '0) begin
                                rdata_q <= mem_q[in_idx];
                            end
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (!stall) begin
                        cnt_q <= cnt_q - 4'd1;
                        // Final countdown step: response is presented next cycle.
                        if (cnt_q <= 4'd1) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            if (wstrb_q == '0) begin
                                rdata_q <= mem_q[idx_q];
                            end
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= 4'd0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    // Writes commit on the edge that leaves RESP, so a reset there aborts them.
    always_ff @(posedge clk) begin
        if (!reset && state_q == RESP) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_q[b]) begin
                    mem_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_iob_native_mem_resp.sv
// ============================================================================
// Module  : tb_iob_native_mem_resp
// Brief   : Vector table, directed corner cases and random traffic vs a model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_iob_native_mem_resp;

    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic        stall;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mdl [1024];
    logic [31:0] last_rd;
    logic [31:0] b2b_a [4];

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          nst;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [11];

    always #5 clk = ~clk;

    iob_native_mem_resp #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_ADDR_W(10),
        .LATENCY   (LATENCY)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .valid(valid),
        .addr (addr),
        .wdata(wdata),
        .wstrb(wstrb),
        .stall(stall),
        .rdata(rdata),
        .ready(ready),
        .busy (busy)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One complete request: starts in an idle cycle, ends in the next idle cycle.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int nst, input logic [31:0] exp_rd, input string nm);
        int lat;
        int k;
        valid = 1'b1;
        addr  = a;
        wdata = d;
        wstrb = s;
        stall = 1'($urandom);
        @(posedge clk); #1;
        valid = 1'b0;
        addr  = $urandom;
        wdata = $urandom;
        wstrb = 4'($urandom);
        lat = 1;
        k   = 0;
        while (!ready && lat < 40) begin
            chk({nm, " busy in wait"}, 32'(busy), 32'd1);
            stall = (k < nst);
            k++;
            @(posedge clk); #1;
            lat++;
        end
        stall = 1'b0;
        chk({nm, " latency"}, 32'(lat), 32'(LATENCY + nst));
        chk({nm, " ready"}, 32'(ready), 32'd1);
        chk({nm, " busy in resp"}, 32'(busy), 32'd1);
        if (s == 4'h0) begin
            chk({nm, " rdata"}, rdata, exp_rd);
            last_rd = exp_rd;
        end else begin
            chk({nm, " rdata kept on write"}, rdata, last_rd);
            mdl[a[11:2]] = merge(mdl[a[11:2]], d, s);
        end
        @(posedge clk); #1;
        chk({nm, " ready after"}, 32'(ready), 32'd0);
        chk({nm, " busy after"}, 32'(busy), 32'd0);
        chk({nm, " rdata held"}, rdata, last_rd);
    endtask

    initial begin
        int          idx;
        int          pulses;
        logic [31:0] a;
        logic [3:0]  s;

        tbl[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0};
        tbl[1]  = '{32'h0000_0010, 32'h0,         4'h0, 0, 32'hDEAD_BEEF};
        tbl[2]  = '{32'h0000_0020, 32'h1122_3344, 4'hF, 0, 32'h0};
        tbl[3]  = '{32'h0000_0020, 32'hAABB_CCDD, 4'h5, 1, 32'h0};
        tbl[4]  = '{32'h0000_0020, 32'h0,         4'h0, 0, 32'h11BB_33DD};
        tbl[5]  = '{32'h0000_0000, 32'h0000_1234, 4'hF, 0, 32'h0};
        tbl[6]  = '{32'h0000_1000, 32'h0,         4'h0, 0, 32'h0000_1234};
        tbl[7]  = '{32'h0000_0010, 32'h0,         4'h0, 3, 32'hDEAD_BEEF};
        tbl[8]  = '{32'h0000_0013, 32'h0,         4'h0, 0, 32'hDEAD_BEEF};
        tbl[9]  = '{32'h0000_0024, 32'h0102_0304, 4'hF, 2, 32'h0};
        tbl[10] = '{32'h0000_0024, 32'hFF00_0000, 4'h8, 0, 32'h0};

        reset = 1'b1;
        valid = 1'b0;
        stall = 1'b0;
        addr  = '0;
        wdata = '0;
        wstrb = '0;
        last_rd = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", 32'(ready), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rdata", rdata, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            do_req(32'(i) << 2, $urandom, 4'hF, 0, 32'h0, "init");
        end

        for (int i = 0; i < 11; i++) begin
            do_req(tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].nst, tbl[i].exp, $sformatf("vec%0d", i));
        end
        do_req(32'h0000_0026, 32'h0, 4'h0, 0, 32'hFF02_0304, "strobe msb");

        // Reset while a write is stalled in WAIT must drop it.
        valid = 1'b1;
        addr  = 32'h0000_0040;
        wdata = 32'hCAFE_F00D;
        wstrb = 4'hF;
        @(posedge clk); #1;
        valid = 1'b0;
        stall = 1'b1;
        chk("abort busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("abort no early ready", 32'(ready), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort ready", 32'(ready), 32'd0);
        chk("abort busy cleared", 32'(busy), 32'd0);
        chk("abort rdata cleared", rdata, 32'h0);
        reset = 1'b0;
        stall = 1'b0;
        last_rd = 32'h0;
        @(posedge clk); #1;
        chk("abort still idle", 32'(busy), 32'd0);
        chk("abort no late ready", 32'(ready), 32'd0);
        do_req(32'h0000_0040, 32'h0, 4'h0, 0, mdl[16], "abort readback");

        // Valid held high: one request accepted every LATENCY+1 cycles.
        b2b_a[0] = 32'h0000_0010;
        b2b_a[1] = 32'h0000_0020;
        b2b_a[2] = 32'h0000_1000;
        b2b_a[3] = 32'h0000_0024;
        pulses = 0;
        stall  = 1'b0;
        for (int t = 0; t < 13; t++) begin
            valid = (t <= 9);
            if (t % 3 == 0 && t <= 9) begin
                addr  = b2b_a[t/3];
                wstrb = 4'h0;
            end else begin
                addr  = $urandom;
                wstrb = 4'($urandom);
            end
            wdata = $urandom;
            chk($sformatf("b2b ready t%0d", t), 32'(ready), 32'(t % 3 == 2));
            chk($sformatf("b2b busy t%0d", t), 32'(busy), 32'(t % 3 != 0 && t < 12));
            if (ready) begin
                pulses++;
                a = b2b_a[t/3];
                chk($sformatf("b2b rdata t%0d", t), rdata, mdl[a[11:2]]);
            end
            @(posedge clk); #1;
        end
        valid = 1'b0;
        chk("b2b pulses", 32'(pulses), 32'd4);
        a = b2b_a[3];
        last_rd = mdl[a[11:2]];

        for (int n = 0; n < 150; n++) begin
            idx = $urandom_range(0, 31);
            a   = ($urandom & 32'hFFFF_F000) | (32'(idx) << 2) | ($urandom & 32'h3);
            s   = ($urandom % 2 == 0) ? 4'($urandom) : 4'h0;
            do_req(a, $urandom, s, $urandom_range(0, 3), mdl[idx], $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
